// File: rtl/bsg_manycore_accel_responder_if.sv
// rtl/bsg_manycore_accel_responder_if.sv - request/response channel bundle for the accelerator responder
interface bsg_manycore_accel_responder_if #(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 28,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7
);
    logic                      req_v_i;
    logic                      req_ready_o;
    logic [1:0]                req_op_i;
    logic [addr_width_p-1:0]   req_addr_i;
    logic [data_width_p-1:0]   req_data_i;
    logic [4:0]                req_reg_id_i;
    logic [x_cord_width_p-1:0] req_src_x_i;
    logic [y_cord_width_p-1:0] req_src_y_i;

    logic                      rsp_v_o;
    logic                      rsp_yumi_i;
    logic [1:0]                rsp_type_o;
    logic [data_width_p-1:0]   rsp_data_o;
    logic [4:0]                rsp_reg_id_o;
    logic [x_cord_width_p-1:0] rsp_dest_x_o;
    logic [y_cord_width_p-1:0] rsp_dest_y_o;

    logic                      busy_o;

    modport slave (
        input  req_v_i, req_op_i, req_addr_i, req_data_i, req_reg_id_i,
               req_src_x_i, req_src_y_i, rsp_yumi_i,
        output req_ready_o, rsp_v_o, rsp_type_o, rsp_data_o, rsp_reg_id_o,
               rsp_dest_x_o, rsp_dest_y_o, busy_o
    );

    modport master (
        output req_v_i, req_op_i, req_addr_i, req_data_i, req_reg_id_i,
               req_src_x_i, req_src_y_i, rsp_yumi_i,
        input  req_ready_o, rsp_v_o, rsp_type_o, rsp_data_o, rsp_reg_id_o,
               rsp_dest_x_o, rsp_dest_y_o, busy_o
    );
endinterface

// File: rtl/bsg_manycore_accel_responder.sv
// rtl/bsg_manycore_accel_responder.sv - CSR load/store/amo responder with accumulate engine and response queue
module bsg_manycore_accel_responder #(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 28,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int csr_els_p      = 16,
    parameter int rsp_fifo_els_p = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_manycore_accel_responder_if.slave io
);
    localparam int idx_w   = $clog2(csr_els_p);
    localparam int ptr_w   = (rsp_fifo_els_p > 1) ? $clog2(rsp_fifo_els_p) : 1;
    localparam int cnt_w   = $clog2(rsp_fifo_els_p + 1);
    localparam int max_len = csr_els_p - 3;

    typedef enum logic {e_idle, e_run} state_e;

    typedef struct packed {
        logic [1:0]                typ;
        logic [data_width_p-1:0]   data;
        logic [4:0]                reg_id;
        logic [x_cord_width_p-1:0] x;
        logic [y_cord_width_p-1:0] y;
    } rsp_s;

    logic [data_width_p-1:0] csr_r [csr_els_p];
    state_e                  state_r, state_n;
    logic [idx_w-1:0]        step_r, step_n, len_r, len_n;
    rsp_s                    fifo_r [rsp_fifo_els_p];
    logic [ptr_w-1:0]        wptr_r, rptr_r;
    logic [cnt_w-1:0]        count_r;

    logic                    accept, running, addr_hit, is_store, is_amo;
    logic                    writable, wr_en, launch, enq, deq, rsp_v;
    logic [idx_w-1:0]        idx, op_idx, launch_len;
    logic [data_width_p-1:0] rd_val, wr_val;
    rsp_s                    new_rsp, head;

    assign running  = (state_r == e_run);
    assign accept   = io.req_v_i & io.req_ready_o;
    assign addr_hit = io.req_addr_i < addr_width_p'(csr_els_p);
    assign idx      = io.req_addr_i[idx_w-1:0];
    assign is_store = (io.req_op_i == 2'd1);
    assign is_amo   = (io.req_op_i == 2'd2);
    assign op_idx   = idx_w'(3) + step_r;

    // STATUS is not stored; it is synthesized from the engine state on read
    always_comb begin
        rd_val = '0;
        if (addr_hit) begin
            if (idx == idx_w'(2)) rd_val = data_width_p'(running);
            else                  rd_val = csr_r[idx];
        end
    end

    assign wr_val     = is_amo ? (rd_val + io.req_data_i) : io.req_data_i;
    // RESULT/STATUS are read-only and everything is frozen while the engine runs
    assign writable   = addr_hit && (idx != idx_w'(1)) && (idx != idx_w'(2)) && !running;
    assign wr_en      = accept && (is_store || is_amo) && writable;
    assign launch     = wr_en && (idx == '0) && (wr_val != '0);
    assign launch_len = (wr_val > data_width_p'(max_len)) ? idx_w'(max_len) : wr_val[idx_w-1:0];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < csr_els_p; i++) csr_r[i] <= '0;
        end else begin
            if (wr_en) csr_r[idx] <= wr_val;
            if (launch)       csr_r[1] <= '0;
            else if (running) csr_r[1] <= csr_r[1] + csr_r[op_idx];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= e_idle;
            step_r  <= '0;
            len_r   <= '0;
        end else begin
            state_r <= state_n;
            step_r  <= step_n;
            len_r   <= len_n;
        end
    end

    always_comb begin
        state_n = state_r;
        step_n  = step_r;
        len_n   = len_r;
        case (state_r)
            e_idle: begin
                if (launch) begin
                    state_n = e_run;
                    step_n  = '0;
                    len_n   = launch_len;
                end
            end
            e_run: begin
                step_n = step_r + idx_w'(1);
                if (step_r == len_r - idx_w'(1)) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    assign io.busy_o = running;

    always_comb begin
        new_rsp.typ    = is_store ? 2'd1 : (is_amo ? 2'd2 : 2'd0);
        new_rsp.data   = is_store ? '0 : rd_val;
        new_rsp.reg_id = io.req_reg_id_i;
        new_rsp.x      = io.req_src_x_i;
        new_rsp.y      = io.req_src_y_i;
    end

    // No bypass: readiness depends only on the registered occupancy
    assign enq            = accept;
    assign rsp_v          = (count_r != '0);
    assign deq            = io.rsp_yumi_i & rsp_v;
    assign io.req_ready_o = (count_r < cnt_w'(rsp_fifo_els_p));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) wptr_r <= (wptr_r == ptr_w'(rsp_fifo_els_p - 1)) ? '0 : wptr_r + ptr_w'(1);
            if (deq) rptr_r <= (rptr_r == ptr_w'(rsp_fifo_els_p - 1)) ? '0 : rptr_r + ptr_w'(1);
            count_r <= count_r + cnt_w'(enq) - cnt_w'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) fifo_r[wptr_r] <= new_rsp;
    end

    assign head            = rsp_v ? fifo_r[rptr_r] : '0;
    assign io.rsp_v_o      = rsp_v;
    assign io.rsp_type_o   = head.typ;
    assign io.rsp_data_o   = head.data;
    assign io.rsp_reg_id_o = head.reg_id;
    assign io.rsp_dest_x_o = head.x;
    assign io.rsp_dest_y_o = head.y;
endmodule

// File: tb/tb_bsg_manycore_accel_responder.sv
// tb/tb_bsg_manycore_accel_responder.sv - scoreboard bench with timed reference model for the accelerator responder
module tb_bsg_manycore_accel_responder;
    localparam int DW = 32, AW = 28, XW = 7, YW = 7, CSR = 16, FD = 2;
    localparam int MAXL = CSR - 3;

    logic clk = 0;
    logic reset_i = 0;
    always #5 clk = ~clk;

    bsg_manycore_accel_responder_if #(.data_width_p(DW), .addr_width_p(AW),
        .x_cord_width_p(XW), .y_cord_width_p(YW)) bus ();

    bsg_manycore_accel_responder #(.data_width_p(DW), .addr_width_p(AW),
        .x_cord_width_p(XW), .y_cord_width_p(YW), .csr_els_p(CSR),
        .rsp_fifo_els_p(FD)) dut (.clk_i(clk), .reset_i(reset_i), .io(bus));

    typedef struct packed {
        logic [1:0]    typ;
        logic [DW-1:0] data;
        logic [4:0]    tag;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0, cyc = 0;
    bit   hold_yumi = 0;
    int   yumi_pct = 60;

    logic [DW-1:0] m_csr [CSR];
    logic [DW-1:0] snap [MAXL];
    bit            launched = 0;
    int            t0 = 0, m_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Engine state seen by a request accepted at edge e (i.e. during the cycle before e)
    function automatic bit m_busy(input int e);
        return launched && (e >= t0 + 1) && (e <= t0 + m_len);
    endfunction

    function automatic logic [DW-1:0] m_result(input int e);
        logic [DW-1:0] s = '0;
        int k;
        if (!launched) return '0;
        k = e - 1 - t0;
        if (k > m_len) k = m_len;
        for (int i = 0; i < k; i++) s = s + snap[i];
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CSR; i++) m_csr[i] = '0;
        launched = 0;
        exp_q.delete();
    endtask

    task automatic model_apply(input int e, input logic [1:0] op, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [4:0] tag,
                               input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [DW-1:0] old, wv;
        bit run, hit;
        exp_t ex;
        run = m_busy(e);
        hit = (a < CSR);
        if (!hit)       old = '0;
        else if (a == 1) old = m_result(e);
        else if (a == 2) old = DW'(run);
        else             old = m_csr[a[3:0]];
        if (op == 2'd1 || op == 2'd2) begin
            wv = (op == 2'd1) ? d : old + d;
            if (hit && a != 1 && a != 2 && !run) begin
                m_csr[a[3:0]] = wv;
                if (a == 0 && wv != 0) begin
                    launched = 1;
                    t0 = e;
                    m_len = (wv > MAXL) ? MAXL : int'(wv);
                    for (int i = 0; i < MAXL; i++) snap[i] = m_csr[3 + i];
                end
            end
        end
        ex.typ  = (op == 2'd1) ? 2'd1 : ((op == 2'd2) ? 2'd2 : 2'd0);
        ex.data = (op == 2'd1) ? '0 : old;
        ex.tag  = tag;
        ex.x    = x;
        ex.y    = y;
        exp_q.push_back(ex);
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [4:0] tag, input logic [XW-1:0] x, input logic [YW-1:0] y);
        int waitc = 0;
        bit done = 0;
        while (!done) begin
            @(negedge clk);
            bus.req_v_i      = 1;
            bus.req_op_i     = op;
            bus.req_addr_i   = a;
            bus.req_data_i   = d;
            bus.req_reg_id_i = tag;
            bus.req_src_x_i  = x;
            bus.req_src_y_i  = y;
            if (bus.req_ready_o) begin
                model_apply(cyc + 1, op, a, d, tag, x, y);
                done = 1;
            end else begin
                waitc++;
                if (waitc > 200) begin
                    tests++;
                    fails++;
                    $display("FAIL issue_timeout: req_ready_o stuck at 0 for %0d cycles", waitc);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1 bus.req_v_i = 0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: checks busy_o every cycle and pops the scoreboard on each dequeue
    always @(negedge clk) begin
        exp_t ex;
        bus.rsp_yumi_i = 0;
        if (reset_i) begin
            check("busy", 64'(bus.busy_o), 64'(m_busy(cyc + 1)));
            if (bus.rsp_v_o) begin
                if (!hold_yumi && $urandom_range(0, 99) < yumi_pct) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: got data %h with empty scoreboard", bus.rsp_data_o);
                    end else begin
                        ex = exp_q.pop_front();
                        check("rsp_type", 64'(bus.rsp_type_o), 64'(ex.typ));
                        check("rsp_data", 64'(bus.rsp_data_o), 64'(ex.data));
                        check("rsp_tag_dest", {bus.rsp_reg_id_o, bus.rsp_dest_x_o, bus.rsp_dest_y_o},
                              {ex.tag, ex.x, ex.y});
                    end
                    bus.rsp_yumi_i = 1;
                end
            end else begin
                check("empty_outputs_zero", {bus.rsp_type_o, bus.rsp_data_o, bus.rsp_reg_id_o,
                      bus.rsp_dest_x_o, bus.rsp_dest_y_o}, 64'd0);
            end
        end
    end

    always @(posedge clk) begin
        if (reset_i && bus.rsp_yumi_i && !bus.rsp_v_o) begin
            tests++;
            fails++;
            $display("FAIL yumi_without_valid: rsp_yumi_i=1 while rsp_v_o=0");
        end
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int r;
        bus.req_v_i = 0; bus.req_op_i = 0; bus.req_addr_i = 0; bus.req_data_i = 0;
        bus.req_reg_id_i = 0; bus.req_src_x_i = 0; bus.req_src_y_i = 0; bus.rsp_yumi_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #2 reset_i = 1;
        #1;
        check("reset_ready", 64'(bus.req_ready_o), 64'd1);
        check("reset_rsp_v", 64'(bus.rsp_v_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);

        // store then load of an operand
        issue(2'd1, 28'd5, 32'h12345678, 5'd3, 7'd2, 7'd1);
        issue(2'd0, 28'd5, 32'h0, 5'd3, 7'd2, 7'd1);

        // accumulate 1+2+3+4, poll STATUS while running
        for (int i = 0; i < 4; i++) issue(2'd1, AW'(3 + i), DW'(i + 1), 5'd1, 7'd0, 7'd0);
        issue(2'd1, 28'd0, 32'd4, 5'd4, 7'd1, 7'd1);
        issue(2'd0, 28'd2, 32'd0, 5'd5, 7'd1, 7'd1);
        repeat (8) @(negedge clk);
        issue(2'd0, 28'd1, 32'd0, 5'd6, 7'd1, 7'd1);

        // amo wraps modulo 2^32
        issue(2'd2, 28'd4, 32'hFFFFFFFF, 5'd7, 7'd3, 7'd3);
        issue(2'd0, 28'd4, 32'd0, 5'd8, 7'd3, 7'd3);
        wait_drain(200);

        // full queue stalls the third request until a dequeue
        hold_yumi = 1;
        issue(2'd0, 28'd3, 32'd0, 5'd9, 7'd4, 7'd4);
        issue(2'd0, 28'd4, 32'd0, 5'd10, 7'd4, 7'd4);
        fork
            issue(2'd0, 28'd5, 32'd0, 5'd11, 7'd4, 7'd4);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #1 check("full_ready", 64'(bus.req_ready_o), 64'd0);
                end
                yumi_pct = 100;
                hold_yumi = 0;
            end
        join
        wait_drain(200);
        yumi_pct = 70;

        // clipped launch, operand store during RUN is dropped
        for (int i = 3; i < CSR; i++) issue(2'd1, AW'(i), $urandom, 5'd12, 7'd5, 7'd5);
        issue(2'd1, 28'd0, 32'd100, 5'd13, 7'd5, 7'd5);
        issue(2'd1, 28'd7, 32'hDEADBEEF, 5'd14, 7'd5, 7'd5);
        repeat (20) @(negedge clk);
        issue(2'd0, 28'd1, 32'd0, 5'd15, 7'd5, 7'd5);
        issue(2'd0, 28'd7, 32'd0, 5'd16, 7'd5, 7'd5);
        issue(2'd0, 28'd0, 32'd0, 5'd17, 7'd5, 7'd5);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 28'h8000003;
            else if (r == 1) a = AW'($urandom_range(16, 40));
            else             a = AW'($urandom_range(0, 15));
            d = (a == 0) ? DW'($urandom_range(0, 20)) : DW'($urandom);
            issue(2'($urandom_range(0, 3)), a, d, 5'($urandom), 7'($urandom), 7'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_drain(300);

        // reset mid-RUN with two responses queued
        hold_yumi = 1;
        issue(2'd1, 28'd0, 32'd13, 5'd18, 7'd6, 7'd6);
        issue(2'd0, 28'd1, 32'd0, 5'd19, 7'd6, 7'd6);
        @(negedge clk);
        #2 reset_i = 0;
        model_reset();
        #1;
        check("rst_rsp_v", 64'(bus.rsp_v_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_result", 64'(dut.csr_r[1]), 64'd0);
        repeat (2) @(negedge clk);
        #2 reset_i = 1;
        hold_yumi = 0;
        #1 check("rst_release_ready", 64'(bus.req_ready_o), 64'd1);
        for (int i = 0; i < CSR; i++) issue(2'd0, AW'(i), 32'd0, 5'(i), 7'd7, 7'd7);
        wait_drain(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
